sdram_cpu_arb: RTL and testbench
================================

SDRAM_CPU_ARB -- requirements
Module: sdram_cpu_arb

Interface
REQ-001 The block SHALL have parameter READ_WAIT, default 6: clk cycles from observed cpu_req_ack toggle to valid cpu_port0 read data.
REQ-002 The block SHALL have parameter WAIT_W, default 3: width of the read-wait counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the only clock, shared with the SDRAM controller.
REQ-004 The block SHALL have port init_n, input, 1 bit: reset, asynchronous and active-low, shared with the SDRAM controller.
REQ-005 The block SHALL have ports cN_req, input, 1 bit, N=0..2: client toggle request; a request is pending while cN_req != cN_ack.
REQ-006 The block SHALL have ports cN_ack, output, 1 bit: client toggle acknowledge.
REQ-007 The block SHALL have ports cN_addr, input, 23 bits: client word address [23:1].
REQ-008 The block SHALL have ports cN_din, input, 16 bits: client write data.
REQ-009 The block SHALL have ports cN_ds, input, 2 bits: client byte enables {hi,lo}.
REQ-010 The block SHALL have ports cN_we, input, 1 bit: client write (1) or read (0).
REQ-011 The block SHALL have ports cN_dout, output, 16 bits: client read data, held until that client's next read completes.
REQ-012 The block SHALL have port cpu_req, output, 1 bit: toggle request to the controller CPU port.
REQ-013 The block SHALL have port cpu_req_ack, input, 1 bit: toggle acknowledge from the controller.
REQ-014 The block SHALL have ports cpu_addr/cpu_din/cpu_ds/cpu_we, outputs, 23/16/2/1 bits: registered request fields to the controller.
REQ-015 The block SHALL have port cpu_port0, input, 16 bits: controller read-data register; the controller's cpu_port select is tied 0 at top level.

Function
REQ-016 The block SHALL implement FSM states IDLE, ISSUE and WAIT, with exactly one controller transaction outstanding.
REQ-017 In IDLE with any client pending, the block SHALL grant round-robin: the first pending client after last_grant, checking cyclically 0->1->2->0.
REQ-018 On grant, in the same edge, the block SHALL latch that client's addr/din/ds/we into cpu_*, toggle cpu_req, record grant and last_grant, and go to ISSUE.
REQ-019 In IDLE with no client pending, the block SHALL leave all outputs unchanged.
REQ-020 In ISSUE, the block SHALL wait until cpu_req_ack == cpu_req, with no timeout.
REQ-021 In ISSUE, if the granted access is a write, the block SHALL toggle cN_ack of the granted client on that edge and go to IDLE.
REQ-022 In ISSUE, if the granted access is a read, the block SHALL load the counter with READ_WAIT-1 and go to WAIT.
REQ-023 In WAIT, the block SHALL decrement the counter each cycle.
REQ-024 At counter 0, the block SHALL capture cpu_port0 into cN_dout of the granted client, toggle its cN_ack and go to IDLE.
REQ-025 Read latency from grant to cN_ack toggle SHALL be (controller ack delay) + READ_WAIT + 1 cycles.
REQ-026 Write latency from grant to cN_ack toggle SHALL be (controller ack delay) + 1 cycles.
REQ-027 cpu_addr/cpu_din/cpu_ds/cpu_we SHALL be stable from grant until the next grant.
REQ-028 A client request that toggles while that client is granted SHALL not affect the current transaction and SHALL be seen as pending after its ack toggles.
REQ-029 Simultaneous pending on all three clients SHALL produce grants in round-robin order, so no client waits more than two other transactions.
REQ-030 The block SHALL return to IDLE in the cycle after the ack; a still-pending client SHALL be granted no earlier than the following cycle.
REQ-031 The block SHALL not modify any other client's cN_dout or cN_ack during a transaction.

Reset
REQ-032 On init_n low, the block SHALL immediately enter IDLE.
REQ-033 Reset values SHALL be: cpu_req=0, cN_ack=0, cN_dout=0, cpu_addr/cpu_din/cpu_ds/cpu_we=0, counter=0, last_grant=2 (client 0 wins first).
REQ-034 Reset mid-transaction SHALL abandon that transaction; since init_n is shared, the controller ack is also 0, so no spurious request is issued.

Structure
REQ-035 A shared package SHALL hold: FSM state enum, client count constant (3), client index typedef (2 bits), and READ_WAIT default.
REQ-036 The round-robin next-grant function SHALL be a single sub-module rr_pick3 (3-bit pending + 2-bit last in, valid + index out, purely combinational); all other logic SHALL be flat.

Verification
REQ-037 The bench SHALL model the controller: toggle cpu_req_ack 4 cycles after cpu_req toggles, and drive cpu_port0 with the read data 5 cycles after the ack.
REQ-038 Single read: c0 reads addr 0x000100 with model data 0xBEEF -> one cpu_req toggle, cpu_addr=0x000100, c0_ack toggles 11 cycles after grant, c0_dout=0xBEEF.
REQ-039 Single write: c1 writes 0x1234, ds=2'b01, addr 0x7F0000 -> cpu_din=0x1234, cpu_ds=01, cpu_we=1, c1_ack toggles 5 cycles after grant, no counter use.
REQ-040 Contention: c0, c1 and c2 all request in the same cycle after reset -> grant order 0,1,2; repeating with all pending and last_grant=0 -> order 1,2,0.
REQ-041 Back-to-back: c2 re-toggles c2_req on the edge c2_ack toggles while c0 is pending -> c0 is served before c2's second request.
REQ-042 Reset mid-read: assert init_n during WAIT -> all outputs 0 asynchronously; first post-reset request completes normally with correct data.
REQ-043 Stall: the model delays ack by 20 cycles -> block holds ISSUE, cpu_* stable, no cN_ack toggle until ack arrives.

Source files
------------

// File: rtl/sdram_cpu_arb_pkg.sv
// Shared types and constants for the three-client SDRAM CPU-port arbiter.
// Clients use a toggle handshake; only one controller transaction is ever outstanding.
package sdram_cpu_arb_pkg;

   localparam int NUM_CLIENTS   = 3;
   localparam int READ_WAIT_DEF = 6;

   typedef logic [1:0] client_idx_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } arb_state_t;

endpackage

// File: rtl/sdram_cpu_arb_if.sv
// Client-side toggle ports and controller CPU-port signals of the arbiter.
// The slave modport is the arbiter; the master modport is the clients plus the controller.
interface sdram_cpu_arb_if;

   logic        c0_req;
   logic        c0_ack;
   logic [22:0] c0_addr;
   logic [15:0] c0_din;
   logic [1:0]  c0_ds;
   logic        c0_we;
   logic [15:0] c0_dout;

   logic        c1_req;
   logic        c1_ack;
   logic [22:0] c1_addr;
   logic [15:0] c1_din;
   logic [1:0]  c1_ds;
   logic        c1_we;
   logic [15:0] c1_dout;

   logic        c2_req;
   logic        c2_ack;
   logic [22:0] c2_addr;
   logic [15:0] c2_din;
   logic [1:0]  c2_ds;
   logic        c2_we;
   logic [15:0] c2_dout;

   logic        cpu_req;
   logic        cpu_req_ack;
   logic [22:0] cpu_addr;
   logic [15:0] cpu_din;
   logic [1:0]  cpu_ds;
   logic        cpu_we;
   logic [15:0] cpu_port0;

   modport slave (
      input  c0_req, c0_addr, c0_din, c0_ds, c0_we,
      output c0_ack, c0_dout,
      input  c1_req, c1_addr, c1_din, c1_ds, c1_we,
      output c1_ack, c1_dout,
      input  c2_req, c2_addr, c2_din, c2_ds, c2_we,
      output c2_ack, c2_dout,
      output cpu_req, cpu_addr, cpu_din, cpu_ds, cpu_we,
      input  cpu_req_ack, cpu_port0
   );

   modport master (
      output c0_req, c0_addr, c0_din, c0_ds, c0_we,
      input  c0_ack, c0_dout,
      output c1_req, c1_addr, c1_din, c1_ds, c1_we,
      input  c1_ack, c1_dout,
      output c2_req, c2_addr, c2_din, c2_ds, c2_we,
      input  c2_ack, c2_dout,
      input  cpu_req, cpu_addr, cpu_din, cpu_ds, cpu_we,
      output cpu_req_ack, cpu_port0
   );

endinterface

// File: rtl/sdram_cpu_arb_rr_pick3.sv
// Combinational round-robin picker: first pending client after 'last', cycling 0->1->2->0.
module rr_pick3
   import sdram_cpu_arb_pkg::*;
(
   input  logic [NUM_CLIENTS-1:0] pending,
   input  client_idx_t            last,
   output logic                   valid,
   output client_idx_t            idx
);

   // A 'last' of 3 never occurs; it falls into the same order as 2 so client 0 leads.
   always_comb begin
      valid = |pending;
      idx   = 2'd0;
      case (last)
         2'd0: begin
            if (pending[1])      idx = 2'd1;
            else if (pending[2]) idx = 2'd2;
            else                 idx = 2'd0;
         end
         2'd1: begin
            if (pending[2])      idx = 2'd2;
            else if (pending[0]) idx = 2'd0;
            else                 idx = 2'd1;
         end
         default: begin
            if (pending[0])      idx = 2'd0;
            else if (pending[1]) idx = 2'd1;
            else                 idx = 2'd2;
         end
      endcase
   end

endmodule

// File: rtl/sdram_cpu_arb.sv
// Three-client round-robin arbiter in front of the SDRAM controller CPU port.
// Reads wait a fixed READ_WAIT cycles after the controller ack before sampling cpu_port0.
module sdram_cpu_arb
   import sdram_cpu_arb_pkg::*;
#(
   parameter int READ_WAIT = READ_WAIT_DEF,
   parameter int WAIT_W    = 3
) (
   input  logic           clk,
   input  logic           init_n,
   sdram_cpu_arb_if.slave bus
);

   logic [NUM_CLIENTS-1:0] req_vec;
   logic [NUM_CLIENTS-1:0] ack_q;
   logic [NUM_CLIENTS-1:0] pending;
   logic [NUM_CLIENTS-1:0] we_vec;
   logic [22:0]            addr_vec [NUM_CLIENTS];
   logic [15:0]            din_vec  [NUM_CLIENTS];
   logic [1:0]             ds_vec   [NUM_CLIENTS];
   logic [15:0]            dout_q   [NUM_CLIENTS];

   arb_state_t             state;
   client_idx_t            grant;
   client_idx_t            last_grant;
   client_idx_t            pick_idx;
   logic                   pick_valid;
   logic [WAIT_W-1:0]      wait_cnt;

   logic                   cpu_req_q;
   logic [22:0]            cpu_addr_q;
   logic [15:0]            cpu_din_q;
   logic [1:0]             cpu_ds_q;
   logic                   cpu_we_q;

   assign req_vec     = {bus.c2_req, bus.c1_req, bus.c0_req};
   assign we_vec      = {bus.c2_we,  bus.c1_we,  bus.c0_we};
   assign addr_vec[0] = bus.c0_addr;
   assign addr_vec[1] = bus.c1_addr;
   assign addr_vec[2] = bus.c2_addr;
   assign din_vec[0]  = bus.c0_din;
   assign din_vec[1]  = bus.c1_din;
   assign din_vec[2]  = bus.c2_din;
   assign ds_vec[0]   = bus.c0_ds;
   assign ds_vec[1]   = bus.c1_ds;
   assign ds_vec[2]   = bus.c2_ds;

   assign pending = req_vec ^ ack_q;

   rr_pick3 u_pick (
      .pending (pending),
      .last    (last_grant),
      .valid   (pick_valid),
      .idx     (pick_idx)
   );

   // Request fields are frozen at grant, so they stay stable until the next grant
   // regardless of what the client does with its own inputs meanwhile.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state      <= IDLE;
         ack_q      <= '0;
         for (int i = 0; i < NUM_CLIENTS; i++) begin
            dout_q[i] <= '0;
         end
         grant      <= 2'd0;
         last_grant <= 2'd2;
         wait_cnt   <= '0;
         cpu_req_q  <= 1'b0;
         cpu_addr_q <= '0;
         cpu_din_q  <= '0;
         cpu_ds_q   <= '0;
         cpu_we_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  grant      <= pick_idx;
                  last_grant <= pick_idx;
                  cpu_addr_q <= addr_vec[pick_idx];
                  cpu_din_q  <= din_vec[pick_idx];
                  cpu_ds_q   <= ds_vec[pick_idx];
                  cpu_we_q   <= we_vec[pick_idx];
                  cpu_req_q  <= ~cpu_req_q;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.cpu_req_ack == cpu_req_q) begin
                  if (cpu_we_q) begin
                     ack_q[grant] <= ~ack_q[grant];
                     state        <= IDLE;
                  end else begin
                     wait_cnt <= WAIT_W'(READ_WAIT - 1);
                     state    <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  dout_q[grant] <= bus.cpu_port0;
                  ack_q[grant]  <= ~ack_q[grant];
                  state         <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.c0_ack   = ack_q[0];
   assign bus.c1_ack   = ack_q[1];
   assign bus.c2_ack   = ack_q[2];
   assign bus.c0_dout  = dout_q[0];
   assign bus.c1_dout  = dout_q[1];
   assign bus.c2_dout  = dout_q[2];
   assign bus.cpu_req  = cpu_req_q;
   assign bus.cpu_addr = cpu_addr_q;
   assign bus.cpu_din  = cpu_din_q;
   assign bus.cpu_ds   = cpu_ds_q;
   assign bus.cpu_we   = cpu_we_q;

endmodule

// File: tb/tb_sdram_cpu_arb.sv
// Directed bench for sdram_cpu_arb with a behavioural SDRAM controller CPU-port model.
// The model acks ackDelay cycles after a cpu_req toggle and presents read data 5 cycles later.
module tb_sdram_cpu_arb;

   logic clk    = 1'b0;
   logic init_n = 1'b0;

   sdram_cpu_arb_if bus ();

   sdram_cpu_arb #(
      .READ_WAIT (6),
      .WAIT_W    (3)
   ) dut (
      .clk    (clk),
      .init_n (init_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int ackDelay    = 4;

   int          ackCnt;
   int          datCnt;
   logic        reqSeen;
   logic [15:0] pendData;

   function automatic logic [15:0] modelRd(input logic [22:0] addr);
      return (addr == 23'h000100) ? 16'hBEEF : (addr[15:0] ^ 16'h5A5A);
   endfunction

   // Controller model shares init_n with the arbiter, as on the real board.
   always @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         bus.cpu_req_ack <= 1'b0;
         bus.cpu_port0   <= 16'h0000;
         reqSeen         <= 1'b0;
         ackCnt          <= 0;
         datCnt          <= 0;
         pendData        <= 16'h0000;
      end else begin
         if (bus.cpu_req != reqSeen) begin
            reqSeen <= bus.cpu_req;
            ackCnt  <= ackDelay - 1;
         end else if (ackCnt > 0) begin
            ackCnt <= ackCnt - 1;
            if (ackCnt == 1) begin
               bus.cpu_req_ack <= ~bus.cpu_req_ack;
               datCnt          <= 5;
               pendData        <= modelRd(bus.cpu_addr);
            end
         end
         if (datCnt > 0) begin
            datCnt <= datCnt - 1;
            if (datCnt == 1) bus.cpu_port0 <= pendData;
         end
      end
   end

   function automatic logic getAck(input int c);
      case (c)
         0:       return bus.c0_ack;
         1:       return bus.c1_ack;
         default: return bus.c2_ack;
      endcase
   endfunction

   // Tallies one comparison result and reports it by tag when it miscompares.
   task automatic checkOutput(input string tag, input logic ok);
      vectors++;
      if (ok !== 1'b1) begin
         miscompares++;
         $error("[TB] FAIL %s", tag);
      end
   endtask

   // Loads a client's request fields and toggles its request line.
   task automatic applyStimulus(input int c, input logic we, input logic [22:0] addr,
                                input logic [15:0] din, input logic [1:0] ds);
      case (c)
         0: begin
            bus.c0_we = we; bus.c0_addr = addr; bus.c0_din = din; bus.c0_ds = ds;
            bus.c0_req = ~bus.c0_req;
         end
         1: begin
            bus.c1_we = we; bus.c1_addr = addr; bus.c1_din = din; bus.c1_ds = ds;
            bus.c1_req = ~bus.c1_req;
         end
         default: begin
            bus.c2_we = we; bus.c2_addr = addr; bus.c2_din = din; bus.c2_ds = ds;
            bus.c2_req = ~bus.c2_req;
         end
      endcase
   endtask

   task automatic waitAck(input int c, input int budget, output int n);
      logic old;
      old = getAck(c);
      n   = 0;
      while (getAck(c) == old && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic waitAnyAck(input int budget, output int who);
      logic [2:0] old;
      logic [2:0] now;
      int         n;
      old = {bus.c2_ack, bus.c1_ack, bus.c0_ack};
      now = old;
      n   = 0;
      who = -1;
      while (now == old && n < budget) begin
         @(posedge clk);
         #1;
         n++;
         now = {bus.c2_ack, bus.c1_ack, bus.c0_ack};
      end
      case (now ^ old)
         3'b001:  who = 0;
         3'b010:  who = 1;
         3'b100:  who = 2;
         3'b000:  who = -1;
         default: who = -2;
      endcase
   endtask

   task automatic doReset();
      #2;
      init_n     = 1'b0;
      bus.c0_req = 1'b0;
      bus.c1_req = 1'b0;
      bus.c2_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      init_n = 1'b1;
   endtask

   initial begin
      int n;
      int who;

      bus.c0_req = 1'b0; bus.c0_addr = '0; bus.c0_din = '0; bus.c0_ds = '0; bus.c0_we = 1'b0;
      bus.c1_req = 1'b0; bus.c1_addr = '0; bus.c1_din = '0; bus.c1_ds = '0; bus.c1_we = 1'b0;
      bus.c2_req = 1'b0; bus.c2_addr = '0; bus.c2_din = '0; bus.c2_ds = '0; bus.c2_we = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      init_n = 1'b1;

      checkOutput("reset_cpu_req",  bus.cpu_req === 1'b0);
      checkOutput("reset_acks",     {bus.c2_ack, bus.c1_ack, bus.c0_ack} === 3'b000);
      checkOutput("reset_c0_dout",  bus.c0_dout === 16'h0000);
      checkOutput("reset_cpu_addr", bus.cpu_addr === 23'h000000);
      checkOutput("reset_cpu_we",   bus.cpu_we === 1'b0);

      // single read from client 0
      applyStimulus(0, 1'b0, 23'h000100, 16'h0000, 2'b11);
      @(posedge clk);
      #1;
      checkOutput("rd_grant_req", bus.cpu_req === 1'b1);
      checkOutput("rd_cpu_addr",  bus.cpu_addr === 23'h000100);
      checkOutput("rd_cpu_we",    bus.cpu_we === 1'b0);
      waitAck(0, 40, n);
      checkOutput("rd_latency",   n === 11);
      checkOutput("rd_c0_dout",   bus.c0_dout === 16'hBEEF);
      checkOutput("rd_one_req",   bus.cpu_req === 1'b1);
      checkOutput("rd_c1_quiet",  bus.c1_ack === 1'b0);

      // single write from client 1
      applyStimulus(1, 1'b1, 23'h7F0000, 16'h1234, 2'b01);
      @(posedge clk);
      #1;
      checkOutput("wr_grant_req", bus.cpu_req === 1'b0);
      checkOutput("wr_cpu_addr",  bus.cpu_addr === 23'h7F0000);
      checkOutput("wr_cpu_din",   bus.cpu_din === 16'h1234);
      checkOutput("wr_cpu_ds",    bus.cpu_ds === 2'b01);
      checkOutput("wr_cpu_we",    bus.cpu_we === 1'b1);
      waitAck(1, 40, n);
      checkOutput("wr_latency",   n === 5);
      checkOutput("wr_c1_dout",   bus.c1_dout === 16'h0000);
      checkOutput("wr_c0_kept",   bus.c0_dout === 16'hBEEF);

      // contention straight after reset: order 0,1,2
      doReset();
      checkOutput("rst2_c0_dout", bus.c0_dout === 16'h0000);
      applyStimulus(0, 1'b0, 23'h000010, 16'h0000, 2'b11);
      applyStimulus(1, 1'b0, 23'h000020, 16'h0000, 2'b11);
      applyStimulus(2, 1'b0, 23'h000030, 16'h0000, 2'b11);
      @(posedge clk);
      #1;
      checkOutput("rr1_first_addr", bus.cpu_addr === 23'h000010);
      waitAnyAck(40, who);
      checkOutput("rr1_order0", who === 0);
      waitAnyAck(40, who);
      checkOutput("rr1_order1", who === 1);
      waitAnyAck(40, who);
      checkOutput("rr1_order2", who === 2);
      checkOutput("rr1_c0_dout", bus.c0_dout === 16'h5A4A);
      checkOutput("rr1_c1_dout", bus.c1_dout === 16'h5A7A);
      checkOutput("rr1_c2_dout", bus.c2_dout === 16'h5A6A);

      // last_grant=0 then all pending: order 1,2,0
      applyStimulus(0, 1'b1, 23'h000001, 16'hAAAA, 2'b11);
      @(posedge clk);
      #1;
      waitAck(0, 40, n);
      checkOutput("rr2_pre_latency", n === 5);
      applyStimulus(0, 1'b1, 23'h000002, 16'h0002, 2'b11);
      applyStimulus(1, 1'b1, 23'h000003, 16'h0003, 2'b11);
      applyStimulus(2, 1'b1, 23'h000004, 16'h0004, 2'b11);
      waitAnyAck(40, who);
      checkOutput("rr2_order0", who === 1);
      waitAnyAck(40, who);
      checkOutput("rr2_order1", who === 2);
      waitAnyAck(40, who);
      checkOutput("rr2_order2", who === 0);
      checkOutput("rr2_c1_dout_kept", bus.c1_dout === 16'h5A7A);

      // back-to-back: c2 re-requests as its ack toggles while c0 is pending
      applyStimulus(2, 1'b1, 23'h000005, 16'h0005, 2'b11);
      @(posedge clk);
      #1;
      checkOutput("b2b_c2_addr", bus.cpu_addr === 23'h000005);
      applyStimulus(0, 1'b1, 23'h000006, 16'h0006, 2'b11);
      waitAck(2, 40, n);
      checkOutput("b2b_c2_latency", n === 5);
      applyStimulus(2, 1'b1, 23'h000007, 16'h0007, 2'b11);
      @(posedge clk);
      #1;
      checkOutput("b2b_c0_next", bus.cpu_addr === 23'h000006);
      waitAnyAck(40, who);
      checkOutput("b2b_order0", who === 0);
      @(posedge clk);
      #1;
      checkOutput("b2b_c2_second", bus.cpu_addr === 23'h000007);
      waitAnyAck(40, who);
      checkOutput("b2b_order1", who === 2);

      // reset while the read is sitting in WAIT
      applyStimulus(0, 1'b0, 23'h000200, 16'h0000, 2'b11);
      @(posedge clk);
      #1;
      repeat (8) @(posedge clk);
      #3;
      init_n     = 1'b0;
      bus.c0_req = 1'b0;
      bus.c1_req = 1'b0;
      bus.c2_req = 1'b0;
      #1;
      checkOutput("midrst_cpu_req",  bus.cpu_req === 1'b0);
      checkOutput("midrst_acks",     {bus.c2_ack, bus.c1_ack, bus.c0_ack} === 3'b000);
      checkOutput("midrst_c0_dout",  bus.c0_dout === 16'h0000);
      checkOutput("midrst_c1_dout",  bus.c1_dout === 16'h0000);
      checkOutput("midrst_c2_dout",  bus.c2_dout === 16'h0000);
      checkOutput("midrst_cpu_addr", bus.cpu_addr === 23'h000000);
      checkOutput("midrst_cpu_din",  bus.cpu_din === 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      init_n = 1'b1;

      applyStimulus(1, 1'b0, 23'h123456, 16'h0000, 2'b11);
      @(posedge clk);
      #1;
      checkOutput("postrst_addr", bus.cpu_addr === 23'h123456);
      waitAck(1, 40, n);
      checkOutput("postrst_latency", n === 11);
      checkOutput("postrst_c1_dout", bus.c1_dout === 16'h6E0C);
      checkOutput("postrst_c0_dout", bus.c0_dout === 16'h0000);

      // controller stalls its ack for 20 cycles
      ackDelay = 20;
      applyStimulus(1, 1'b1, 23'h055555, 16'hA5A5, 2'b11);
      @(posedge clk);
      #1;
      repeat (15) @(posedge clk);
      #1;
      checkOutput("stall_addr",   bus.cpu_addr === 23'h055555);
      checkOutput("stall_din",    bus.cpu_din === 16'hA5A5);
      checkOutput("stall_we",     bus.cpu_we === 1'b1);
      checkOutput("stall_c1_ack", bus.c1_ack === 1'b1);
      waitAck(1, 40, n);
      checkOutput("stall_latency", (n + 15) === 21);
      checkOutput("stall_c1_ack_after", bus.c1_ack === 1'b0);
      ackDelay = 4;

      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired before the sequence finished");
      $fatal(1, "[TB] watchdog");
   end

endmodule
